// File: rtl/kab_io_pkg.sv
// Shared definitions for the core IO-bus interrupt controller: register offsets,
// source ID encoding and controller FSM states.
package kab_io_pkg;

  localparam int ID_W = 4;
  localparam logic [ID_W-1:0] URGENT_ID = 4'd8;

  localparam logic [29:0] OFF_MASK   = 30'd0;
  localparam logic [29:0] OFF_PEND   = 30'd1;
  localparam logic [29:0] OFF_STATUS = 30'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: bit 8 (urgent) wins, otherwise the lowest set index.
module int_prio_enc
  import kab_io_pkg::*;
(
  input  logic [8:0]      elig_i,
  output logic            vld_o,
  output logic [ID_W-1:0] id_o
);

  always_comb begin
    vld_o = |elig_i;
    id_o  = '0;
    if (elig_i[8]) begin
      id_o = URGENT_ID;
    end else begin
      // Scan downward so the lowest eligible index is the last assignment.
      for (int i = 7; i >= 0; i--) begin
        if (elig_i[i]) id_o = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/ext_int_ctrl.sv
// External interrupt controller: edge-detected maskable/urgent sources, a
// single outstanding request to the core, and a small IO-bus register file.
module ext_int_ctrl
  import kab_io_pkg::*;
#(
  parameter logic [29:0] BASE_ADDR = 30'h0000_0100,
  parameter int          NUM_SRC   = 8
) (
  input  logic                Sys_Clock,
  input  logic                Sys_Reset,
  input  logic [29:0]         Sys_Address,
  input  logic                Sys_WrEn,
  input  logic                Sys_RdEn,
  input  logic [31:0]         Sys_WrData,
  output logic [31:0]         Sys_RdData,
  input  logic [NUM_SRC-1:0]  IntReq,
  input  logic                UrgentReq,
  output logic                K_IntReq,
  output logic [ID_W-1:0]     K_IntID,
  input  logic                I_IntAck
);

  state_e               state_q, state_d;
  logic [ID_W-1:0]      kid_q, kid_d;
  logic [NUM_SRC-1:0]   mask_q, mask_d;
  logic [NUM_SRC:0]     pend_q, pend_d;
  logic [NUM_SRC:0]     prev_q;
  logic                 armed_q;
  logic [31:0]          rd_q, rd_d;

  logic [NUM_SRC:0]     edge_s, elig_s, ack_clr_s, clr_s;
  logic [29:0]          off_s;
  logic                 hit_mask, hit_pend, hit_stat;
  logic                 win_vld;
  logic [ID_W-1:0]      win_id;
  logic                 unused_wdata;

  assign unused_wdata = ^Sys_WrData[31:NUM_SRC+1];

  assign off_s    = Sys_Address - BASE_ADDR;
  assign hit_mask = (off_s == OFF_MASK);
  assign hit_pend = (off_s == OFF_PEND);
  assign hit_stat = (off_s == OFF_STATUS);

  // The first cycle after reset only primes the history, so a source held
  // high across reset release is not mistaken for a fresh rising edge.
  assign edge_s = armed_q ? ({UrgentReq, IntReq} & ~prev_q) : '0;
  assign elig_s = {pend_q[NUM_SRC], pend_q[NUM_SRC-1:0] & mask_q};

  int_prio_enc u_prio (
    .elig_i (elig_s),
    .vld_o  (win_vld),
    .id_o   (win_id)
  );

  always_comb begin
    state_d   = state_q;
    kid_d     = kid_q;
    ack_clr_s = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          kid_d   = win_id;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // The request is never withdrawn; only the ack ends it.
        if (I_IntAck) begin
          ack_clr_s = (NUM_SRC+1)'(1) << kid_q;
          state_d   = ST_GAP;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mask_d = mask_q;
    if (Sys_WrEn && hit_mask) mask_d = Sys_WrData[NUM_SRC-1:0];

    clr_s  = ack_clr_s | ((Sys_WrEn && hit_pend) ? Sys_WrData[NUM_SRC:0] : '0);
    // New edges override any coincident clear.
    pend_d = (pend_q & ~clr_s) | edge_s;

    rd_d = '0;
    if (Sys_RdEn) begin
      if (hit_mask)      rd_d = 32'(mask_q);
      else if (hit_pend) rd_d = 32'(pend_q);
      else if (hit_stat) rd_d = {24'd0, kid_q, 3'd0, K_IntReq};
    end
  end

  always_ff @(posedge Sys_Clock) begin
    if (Sys_Reset) begin
      state_q <= ST_IDLE;
      kid_q   <= '0;
      mask_q  <= '0;
      pend_q  <= '0;
      prev_q  <= '0;
      armed_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      kid_q   <= kid_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      prev_q  <= {UrgentReq, IntReq};
      armed_q <= 1'b1;
      rd_q    <= rd_d;
    end
  end

  assign K_IntReq   = (state_q == ST_REQ);
  assign K_IntID    = kid_q;
  assign Sys_RdData = rd_q;

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Bench for ext_int_ctrl: register/handshake vector table, directed corner
// sequences, and random traffic against a cycle-level reference model.
module tb_ext_int_ctrl;
  import kab_io_pkg::*;

  localparam logic [29:0] BASE = 30'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] addr;
  logic        wr, rd, urg, ack;
  logic [31:0] wd, rdata;
  logic [7:0]  irq;
  logic        kreq;
  logic [3:0]  kid;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ext_int_ctrl #(.BASE_ADDR(BASE), .NUM_SRC(8)) dut (
    .Sys_Clock   (clk),
    .Sys_Reset   (rst),
    .Sys_Address (addr),
    .Sys_WrEn    (wr),
    .Sys_RdEn    (rd),
    .Sys_WrData  (wd),
    .Sys_RdData  (rdata),
    .IntReq      (irq),
    .UrgentReq   (urg),
    .K_IntReq    (kreq),
    .K_IntID     (kid),
    .I_IntAck    (ack)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fresh();
    irq = '0; urg = 1'b0; wr = 1'b0; rd = 1'b0; ack = 1'b0; wd = '0; addr = BASE;
    rst = 1'b1; tick(); tick();
    rst = 1'b0; tick();
  endtask

  task automatic bus_wr(input int off, input logic [31:0] d);
    addr = BASE + 30'(off); wd = d; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic bus_rd(input int off, output logic [31:0] d);
    addr = BASE + 30'(off); rd = 1'b1;
    tick();
    rd = 1'b0;
    d = rdata;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          wr, rd, ack;
    int          off;
    logic [31:0] wd;
    logic [7:0]  irq;
    bit          xreq;
    logic [3:0]  xid;
    logic [31:0] xrd;
  } tv_t;

  tv_t tbl[13];

  // ---------------- reference model ----------------
  logic [7:0]  m_mask;
  logic [8:0]  m_pend, m_prev;
  int          m_ph;      // 0 idle, 1 request outstanding, 2 gap
  logic [3:0]  m_id;
  logic [31:0] m_rd;
  int          r_off;

  task automatic model_step();
    logic [8:0] cur, clr;
    int win;
    cur = {urg, irq};
    clr = '0;
    m_rd = 0;
    if (rd) begin
      case (r_off)
        0: m_rd = {24'd0, m_mask};
        1: m_rd = {23'd0, m_pend};
        2: m_rd = {24'd0, m_id, 3'd0, (m_ph == 1)};
        default: m_rd = 0;
      endcase
    end
    if (wr && r_off == 1) clr = wd[8:0];
    if (m_ph == 1) begin
      if (ack) begin
        clr[m_id] = 1'b1;
        m_ph = 2;
      end
    end else if (m_ph == 2) begin
      m_ph = 0;
    end else begin
      win = -1;
      if (m_pend[8]) win = 8;
      else for (int i = 0; i < 8; i++) if (win < 0 && m_pend[i] && m_mask[i]) win = i;
      if (win >= 0) begin
        m_id = 4'(win);
        m_ph = 1;
      end
    end
    if (wr && r_off == 0) m_mask = wd[7:0];
    m_pend = (m_pend & ~clr) | (cur & ~m_prev);
    m_prev = cur;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int hits;
    logic [31:0] r;

    //            wr rd ack off wd            irq    xreq xid   xrd
    tbl[0]  = '{1, 0, 0, 0, 32'h08,       8'h00, 0, 4'd0, 32'h0};
    tbl[1]  = '{0, 1, 0, 0, 32'h0,        8'h00, 0, 4'd0, 32'h08};
    tbl[2]  = '{0, 0, 0, 0, 32'h0,        8'h08, 0, 4'd0, 32'h0};
    tbl[3]  = '{0, 1, 0, 1, 32'h0,        8'h08, 1, 4'd3, 32'h008};
    tbl[4]  = '{0, 1, 0, 2, 32'h0,        8'h08, 1, 4'd3, 32'h31};
    tbl[5]  = '{0, 0, 1, 0, 32'h0,        8'h00, 0, 4'd0, 32'h0};
    tbl[6]  = '{0, 1, 1, 1, 32'h0,        8'h00, 0, 4'd0, 32'h0};
    tbl[7]  = '{0, 1, 1, 0, 32'h0,        8'h00, 0, 4'd0, 32'h08};
    tbl[8]  = '{1, 1, 0, 3, 32'hFFFF_FFFF, 8'h00, 0, 4'd0, 32'h0};
    tbl[9]  = '{1, 0, 0, 2, 32'hFFFF_FFFF, 8'h00, 0, 4'd0, 32'h0};
    tbl[10] = '{0, 1, 0, 0, 32'h0,        8'h00, 0, 4'd0, 32'h08};
    tbl[11] = '{1, 1, 0, 0, 32'h1A5,      8'h00, 0, 4'd0, 32'h08};
    tbl[12] = '{0, 1, 0, 0, 32'h0,        8'h00, 0, 4'd0, 32'hA5};

    // Reset state
    fresh();
    chk("rst_kreq", kreq, 0);
    chk("rst_kid", kid, 0);
    chk("rst_rdata", rdata, 0);
    bus_rd(2, d); chk("rst_status", d, 0);
    bus_rd(1, d); chk("rst_pend", d, 0);

    // Table: basic service of IntReq[3] plus register-map behaviour
    for (int i = 0; i < 13; i++) begin
      wr = tbl[i].wr; rd = tbl[i].rd; ack = tbl[i].ack;
      addr = BASE + 30'(tbl[i].off); wd = tbl[i].wd; irq = tbl[i].irq;
      tick();
      wr = 0; rd = 0; ack = 0;
      chk($sformatf("tv%0d_kreq", i), kreq, tbl[i].xreq);
      if (tbl[i].xreq) chk($sformatf("tv%0d_kid", i), kid, tbl[i].xid);
      chk($sformatf("tv%0d_rd", i), rdata, tbl[i].xrd);
    end

    // Two sources at once: lowest index first, then the other after the gap
    fresh();
    bus_wr(0, 32'hFF);
    irq = 8'h24; tick(); tick();
    chk("dual_req1", kreq, 1); chk("dual_id1", kid, 2);
    ack = 1; tick(); ack = 0;
    chk("dual_ackdrop", kreq, 0);
    tick(); chk("dual_gap", kreq, 0);
    tick(); chk("dual_req2", kreq, 1); chk("dual_id2", kid, 5);
    ack = 1; tick(); ack = 0;

    // Urgent beats a masked source, which stays pending but never requests
    fresh();
    urg = 1; irq = 8'h01; tick(); tick();
    chk("urg_req", kreq, 1); chk("urg_id", kid, 8);
    ack = 1; tick(); ack = 0;
    bus_rd(1, d); chk("urg_pend", d, 32'h001);
    hits = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (kreq) hits++; end
    chk("urg_noreq0", hits, 0);

    // Software mask/W1C during an outstanding request does not retract it
    fresh();
    bus_wr(0, 32'h02);
    irq = 8'h02; tick(); tick();
    chk("hold_req", kreq, 1); chk("hold_id", kid, 1);
    bus_wr(0, 32'h0);
    bus_wr(1, 32'h02);
    bus_rd(2, d); chk("hold_status", d, 32'h11);
    hits = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (kreq) hits++; end
    chk("hold_kept", hits, 3);
    ack = 1; tick(); ack = 0;
    chk("hold_ackdrop", kreq, 0);
    hits = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (kreq) hits++; end
    chk("hold_noreq", hits, 0);
    bus_rd(1, d); chk("hold_pend", d, 0);

    // Ack coincident with a new edge on the same source: set wins
    fresh();
    bus_wr(0, 32'h10);
    irq = 8'h10; tick(); tick();
    chk("race_req1", kreq, 1); chk("race_id1", kid, 4);
    irq = 8'h00; tick();
    irq = 8'h10; ack = 1; tick(); ack = 0;
    chk("race_ackdrop", kreq, 0);
    bus_rd(1, d); chk("race_pend", d, 32'h010);
    tick(); chk("race_req2", kreq, 1); chk("race_id2", kid, 4);
    ack = 1; tick(); ack = 0;

    // Reset during a request; source held high across release stays quiet
    fresh();
    bus_wr(0, 32'hFF);
    irq = 8'h40; tick(); tick();
    chk("rreq_req", kreq, 1); chk("rreq_id", kid, 6);
    rst = 1; tick();
    chk("rreq_drop", kreq, 0); chk("rreq_rd", rdata, 0);
    tick(); rst = 0; tick();
    bus_rd(0, d); chk("rreq_mask", d, 0);
    bus_rd(1, d); chk("rreq_pend", d, 0);
    bus_rd(2, d); chk("rreq_status", d, 0);
    bus_wr(0, 32'hFF);
    hits = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (kreq) hits++; end
    chk("rreq_held_noreq", hits, 0);
    bus_rd(1, d); chk("rreq_held_pend", d, 0);
    irq = 8'h00; tick();
    irq = 8'h40; tick(); tick();
    chk("rreq_rerise", kreq, 1); chk("rreq_rerise_id", kid, 6);
    ack = 1; tick(); ack = 0;

    // Random traffic against the reference model
    fresh();
    m_mask = '0; m_pend = '0; m_prev = '0; m_ph = 0; m_id = '0; m_rd = '0;
    for (int c = 0; c < 1500; c++) begin
      r = $urandom;
      irq = irq ^ (r[7:0] & r[15:8] & r[23:16]);
      if ($urandom_range(15) == 0) urg = ~urg;
      ack = (m_ph == 1) ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
      wr = ($urandom_range(5) == 0);
      rd = ($urandom_range(2) == 0);
      r_off = $urandom_range(4);
      if (r_off == 4) r_off = -1;
      addr = (r_off >= 0) ? BASE + 30'(r_off) : BASE - 30'd1;
      wd = $urandom;
      model_step();
      tick();
      chk($sformatf("rnd%0d_kreq", c), kreq, (m_ph == 1));
      if (m_ph == 1) chk($sformatf("rnd%0d_kid", c), kid, m_id);
      chk($sformatf("rnd%0d_rd", c), rdata, m_rd);
    end
    wr = 0; rd = 0; ack = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
